// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Contents: state codes, supported opcodes, ALUOp / ALUSrcB / PCSrc
// encodings, the control-word struct produced by the output decoder, and
// a helper that tells whether an opcode is handled by the FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dst;
    logic       i_or_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational Moore output decode: maps a state code to the full
// datapath control word. Anything a state does not mention stays 0.
//   state : state code to decode
//   ctrl  : control word (see ctrl_t)
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Precompute branch target while registers are read.
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: ctrl.i_or_d = 1'b1;
      S_MEMWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM (Moore). Holds the state register and the
// next-state logic; output decode lives in ctrl_output_decode.
//   Clk, Reset        : clock, synchronous active-high reset
//   Opcode            : instr[31:26] from the IR (stable after FETCH)
//   Zero              : ALU zero flag, qualifies Branch into PCEn
//   datapath controls : MemtoReg .. PCSrc, PCEn
//   State, Illegal    : debug state code; unsupported-opcode flag
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State,
  output logic       Illegal
);

  state_t state_q, state_d;
  state_t dec_state;
  logic   illegal_q;
  ctrl_t  ctrl;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == S_DECODE) && !is_supported(Opcode);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR still holds the lw/sw opcode here, so it selects the memory op.
      S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;  // writebacks, branch, jump, codes 12-15
    endcase
  end

  // While in reset the non-enable outputs already look like FETCH, so the
  // datapath sees a clean PC+4 setup as reset releases.
  assign dec_state = Reset ? S_FETCH : state_q;

  ctrl_output_decode u_dec (
    .state (dec_state),
    .ctrl  (ctrl)
  );

  assign MemtoReg = ctrl.mem_to_reg;
  assign RegDst   = ctrl.reg_dst;
  assign IorD     = ctrl.i_or_d;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign Branch   = ctrl.branch;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSrc    = ctrl.pc_src;
  assign IRWrite  = ctrl.ir_write  & ~Reset;
  assign MemWrite = ctrl.mem_write & ~Reset;
  assign PCWrite  = ctrl.pc_write  & ~Reset;
  assign RegWrite = ctrl.reg_write & ~Reset;
  assign PCEn     = (ctrl.pc_write | (ctrl.branch & Zero)) & ~Reset;
  assign State    = state_q;
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction sequence, a
// per-instruction state-path model plus a per-state control table, checked
// every cycle by one compare process; latencies and a few values pinned
// with literals.
module tb_multicycle_control_fsm;

  logic       Clk = 0, Reset = 1, Zero = 0;
  logic [5:0] Opcode = 6'b0;
  logic       MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite;
  logic       Branch, RegWrite, PCEn, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  multicycle_control_fsm dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .Branch(Branch), .RegWrite(RegWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCEn(PCEn), .State(State), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;
  logic       exp_valid = 0, exp_reset = 1, exp_illegal = 0, pend_illegal = 0;
  int         exp_state = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word per state, bit order:
  // {MemtoReg,RegDst,IorD,ALUSrcA,IRWrite,MemWrite,PCWrite,Branch,RegWrite,
  //  ALUSrcB,ALUOp,PCSrc}
  function automatic logic [14:0] ctrl_of(input int s);
    case (s)
      0:       return {9'b0000_1010_0, 2'b01, 2'b00, 2'b00};
      1:       return {9'b0000_0000_0, 2'b11, 2'b00, 2'b00};
      2, 9:    return {9'b0001_0000_0, 2'b10, 2'b00, 2'b00};
      3:       return {9'b0010_0000_0, 2'b00, 2'b00, 2'b00};
      4:       return {9'b1000_0000_1, 2'b00, 2'b00, 2'b00};
      5:       return {9'b0010_0100_0, 2'b00, 2'b00, 2'b00};
      6:       return {9'b0001_0000_0, 2'b00, 2'b10, 2'b00};
      7:       return {9'b0100_0000_1, 2'b00, 2'b00, 2'b00};
      8:       return {9'b0001_0001_0, 2'b00, 2'b01, 2'b01};
      10:      return {9'b0000_0000_1, 2'b00, 2'b00, 2'b00};
      11:      return {9'b0000_0010_0, 2'b00, 2'b00, 2'b10};
      default: return 15'h0;
    endcase
  endfunction

  // State path visited by one instruction, starting at FETCH.
  function automatic void get_path(input logic [5:0] op, output int n,
                                   output int p[6]);
    case (op)
      6'b100011: begin n = 5; p = '{0, 1, 2, 3, 4, 0}; end
      6'b101011: begin n = 4; p = '{0, 1, 2, 5, 0, 0}; end
      6'b000000: begin n = 4; p = '{0, 1, 6, 7, 0, 0}; end
      6'b001000: begin n = 4; p = '{0, 1, 9, 10, 0, 0}; end
      6'b000100: begin n = 3; p = '{0, 1, 8, 0, 0, 0}; end
      6'b000010: begin n = 3; p = '{0, 1, 11, 0, 0, 0}; end
      default:   begin n = 2; p = '{0, 1, 0, 0, 0, 0}; end
    endcase
  endfunction

  // Compare process: every cycle once the model is armed.
  always @(negedge Clk) begin
    if (exp_valid) begin
      logic [14:0] e;
      logic        pcen;
      e = ctrl_of(exp_reset ? 0 : exp_state);
      if (exp_reset) e = e & ~15'h0740;
      pcen = !exp_reset && (e[8] || (e[7] && Zero));
      chk($sformatf("outs st=%0d", exp_state),
          int'({MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
                Branch, RegWrite, ALUSrcB, ALUOp, PCSrc}), int'(e));
      chk($sformatf("pcen st=%0d", exp_state), int'(PCEn), int'(pcen));
      chk("state", int'(State), exp_state);
      chk($sformatf("illegal st=%0d", exp_state), int'(Illegal),
          int'(exp_illegal));
    end
  end

  // Run one instruction from FETCH; optionally assert Reset in step abort_at.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int exp_lat, input int abort_at);
    int n, lat;
    int p[6];
    get_path(op, n, p);
    lat = 0;
    for (int k = 0; k < n; k++) begin
      exp_state   = p[k];
      exp_illegal = (k == 0) ? pend_illegal : 1'b0;
      Opcode      = op;
      Zero        = z;
      if (k == abort_at) begin
        Reset = 1; exp_reset = 1;
        @(posedge Clk); #1;
        exp_state = 0; exp_illegal = 0; pend_illegal = 0;
        chk("reset_to_fetch", int'(State), 0);
        @(posedge Clk); #1;
        Reset = 0; exp_reset = 0;
        chk("fetch_after_reset", int'(State), 0);
        return;
      end
      @(posedge Clk); #1;
      if (lat == 0 && State == 4'd0) lat = k + 1;
    end
    pend_illegal = (n == 2);
    chk($sformatf("latency op=%b", op), lat, exp_lat);
  endtask

  initial begin
    @(posedge Clk); #1;
    exp_valid = 1;
    @(posedge Clk); #1;
    chk("reset_state", int'(State), 0);
    Reset = 0; exp_reset = 0;

    run_instr(6'b100011, 1'b0, 5, -1);   // lw
    run_instr(6'b101011, 1'b1, 4, -1);   // sw, Zero must not leak into PCEn
    run_instr(6'b000100, 1'b1, 3, -1);   // beq taken
    run_instr(6'b000100, 1'b0, 3, -1);   // beq not taken
    run_instr(6'b000000, 1'b0, 4, -1);   // R-type
    run_instr(6'b000010, 1'b0, 3, -1);   // j
    run_instr(6'b001000, 1'b1, 4, -1);   // addi
    run_instr(6'b111111, 1'b0, 2, -1);   // unsupported
    chk("illegal_lit", int'(Illegal), 1);
    run_instr(6'b111111, 1'b1, 2, -1);   // back-to-back unsupported
    chk("illegal_lit2", int'(Illegal), 1);
    run_instr(6'b100011, 1'b0, 5, 3);    // lw, reset while in MEMRD
    run_instr(6'b100011, 1'b1, 5, -1);   // lw clean after reset
    chk("illegal_clear", int'(Illegal), 0);

    exp_valid = 0;
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
